cpu_trace_monitor: RTL and testbench

- Synthesizable commit/trace monitor for the pipelined cpu. It taps the writeback register-write and memory-stage signals and records REG, LOAD, STORE and HALT events into a parametrised trace FIFO drained over a valid/ready port.
- It keeps saturating cycle, instruction and per-channel event counters (stall, flush, forwarding, ...).
- A watchdog times out runaway programs.
- It sits beside `cpu` in the top level so hardware runs produce the same trace stream the simulation bench writes.

---
 rtl/cpu_trace_pkg.sv | 29 ++
 rtl/cpu_trace_monitor_fifo.sv | 67 ++++++
 rtl/cpu_trace_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types and sizing helpers for the cpu commit/trace
// monitor.
//   trace_type_e  - trace entry kind (REG, LOAD, STORE, HALT)
//   state_e       - monitor run state as reported on state_o
//   trace_entry_w - packed entry width {type, addr, data}
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    TR_REG   = 2'd0,
    TR_LOAD  = 2'd1,
    TR_STORE = 2'd2,
    TR_HALT  = 2'd3
  } trace_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned TYPE_W = 2;

  // Entry layout, MSB first: type[1:0], addr[DATA_W-1:0], data[DATA_W-1:0].
  function automatic int unsigned trace_entry_w(input int unsigned data_w);
    return TYPE_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// trace_fifo_mw: multi-write (0..3 per cycle), single-read FIFO.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush (pointers and count to zero)
//   push_n       number of entries written this cycle (0..3)
//   push_data    entries; slot 0 is written first, then 1, then 2
//   pop          consumer accepts the head (ignored when empty)
//   head         head entry; all zeros while empty
//   valid        FIFO not empty
//   occupancy    current entry count (0..DEPTH)
// The caller guarantees push_n never exceeds free space (after a same-cycle
// pop); this block does not check it.
module trace_fifo_mw #(
  parameter  int unsigned WIDTH = 34,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [1:0]            push_n,
  input  logic [2:0][WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  valid,
  output logic [CW-1:0]         occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_en;

  assign valid     = (count != '0);
  assign pop_en    = pop & valid;
  assign occupancy = count;
  // Head comes straight from the storage register at rd_ptr; an occupied slot
  // is never overwritten, so it holds steady while the consumer stalls.
  assign head      = valid ? mem[rd_ptr] : '0;

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_en);
      count  <= count + CW'(push_n) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (!clear && i < 32'(push_n)) begin
        mem[wr_ptr + AW'(i)] <= push_data[i];
      end
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: commit/trace monitor tapping the cpu writeback and
// memory stages.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse, IDLE -> RUN
//   clear               synchronous return to reset values (wins over all)
//   halt_i              halt reached memory/writeback
//   reg_we_i/rd/data    register-file write
//   mem_re_i/we_i       memory read / write
//   mem_addr_i/data_i   memory address and store/load data
//   event_i             per-channel event strobes
//   trace_valid/ready   trace FIFO head handshake
//   trace_type/addr/data head entry fields
//   cycle_cnt, inst_cnt RUN cycles, retired instructions (saturating)
//   event_cnt           per-channel counters, channel k at [k*CNT_W +: CNT_W]
//   drop_cnt, overflow  dropped entries, sticky drop flag
//   state_o             0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned NUM_EVENTS = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WDOG_LIMIT = 100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        halt_i,
  input  logic                        reg_we_i,
  input  logic [REG_W-1:0]            reg_rd_i,
  input  logic [DATA_W-1:0]           reg_data_i,
  input  logic                        mem_re_i,
  input  logic                        mem_we_i,
  input  logic [DATA_W-1:0]           mem_addr_i,
  input  logic [DATA_W-1:0]           mem_data_i,
  input  logic [NUM_EVENTS-1:0]       event_i,
  output logic                        trace_valid,
  input  logic                        trace_ready,
  output logic [1:0]                  trace_type,
  output logic [DATA_W-1:0]           trace_addr,
  output logic [DATA_W-1:0]           trace_data,
  output logic [CNT_W-1:0]            cycle_cnt,
  output logic [CNT_W-1:0]            inst_cnt,
  output logic [NUM_EVENTS*CNT_W-1:0] event_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic [1:0]                  state_o,
  output logic                        overflow
);

  localparam int unsigned ENTRY_W = trace_entry_w(DATA_W);
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH) + 1;

  state_e state, state_next;
  logic   run;

  logic [CNT_W-1:0] ev_cnt [NUM_EVENTS];
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] inst_inc;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;
  logic             retire;

  logic                     fifo_valid;
  logic                     pop;
  logic [ENTRY_W-1:0]       head;
  logic [OCC_W-1:0]         occ;
  logic [1:0]               push_n;
  logic [2:0][ENTRY_W-1:0]  push_data;

  logic             mem_cand;
  logic [1:0]       nh_cnt;
  logic             nh_fit;
  logic             push_nh;
  logic             push_halt;
  logic             drop_now;
  logic [1:0]       mem_type;
  logic [DATA_W-1:0] halt_data;
  logic [ENTRY_W-1:0] reg_entry;
  logic [ENTRY_W-1:0] mem_entry;
  logic [ENTRY_W-1:0] halt_entry;

  assign run = (state == ST_RUN);

  // ---------------------------------------------------------------- counters
  assign retire    = halt_i | reg_we_i | mem_we_i;
  assign cycle_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
  assign inst_inc  = (retire && inst_cnt != '1) ? inst_cnt + CNT_W'(1) : inst_cnt;
  // One spare bit catches the carry when up to two drops land near all-ones.
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W + 1)'(nh_cnt);
  assign drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      for (int unsigned k = 0; k < NUM_EVENTS; k++) ev_cnt[k] <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      for (int unsigned k = 0; k < NUM_EVENTS; k++) ev_cnt[k] <= '0;
    end else if (run) begin
      cycle_cnt <= cycle_inc;
      inst_cnt  <= inst_inc;
      if (drop_now) begin
        drop_cnt <= drop_next;
        overflow <= 1'b1;
      end
      for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
        if (event_i[k] && ev_cnt[k] != '1) ev_cnt[k] <= ev_cnt[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    event_cnt = '0;
    for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
      event_cnt[k*CNT_W +: CNT_W] = ev_cnt[k];
    end
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (halt_i)                                  state_next = ST_HALTED;
        else if (64'(cycle_inc) >= 64'(WDOG_LIMIT))  state_next = ST_TIMEOUT;
      end
      default: state_next = state;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  assign state_o = state;

  // ------------------------------------------------------------ trace pushes
  assign mem_cand = mem_we_i | mem_re_i;
  assign nh_cnt   = {1'b0, reg_we_i} + {1'b0, mem_cand};
  // Non-HALT entries may fill at most FIFO_DEPTH-1 slots, so the last slot is
  // always free for a HALT. HALT ends RUN, so nothing is pushed after it and
  // the HALT push needs no capacity check of its own.
  assign nh_fit    = (32'(occ) - 32'(pop) + 32'(nh_cnt)) <= (FIFO_DEPTH - 1);
  assign push_nh   = run & nh_fit;
  assign push_halt = run & halt_i;
  assign drop_now  = run & ~nh_fit & (nh_cnt != 2'd0);

  assign mem_type   = mem_we_i ? TR_STORE : TR_LOAD;
  assign halt_data  = DATA_W'(inst_inc);
  assign reg_entry  = {TR_REG, DATA_W'(reg_rd_i), reg_data_i};
  assign mem_entry  = {mem_type, mem_addr_i, mem_data_i};
  assign halt_entry = {TR_HALT, {DATA_W{1'b0}}, halt_data};

  // Candidates are packed into consecutive slots in REG, MEM, HALT order.
  always_comb begin
    push_data = '0;
    push_n    = 2'd0;
    if (push_nh && reg_we_i) begin
      push_data[push_n] = reg_entry;
      push_n            = push_n + 2'd1;
    end
    if (push_nh && mem_cand) begin
      push_data[push_n] = mem_entry;
      push_n            = push_n + 2'd1;
    end
    if (push_halt) begin
      push_data[push_n] = halt_entry;
      push_n            = push_n + 2'd1;
    end
  end

  assign pop = fifo_valid & trace_ready;

  trace_fifo_mw #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push_n    (push_n),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .occupancy (occ)
  );

  assign trace_valid = fifo_valid;
  assign trace_type  = head[ENTRY_W-1 -: 2];
  assign trace_addr  = head[2*DATA_W-1 -: DATA_W];
  assign trace_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_cpu_trace_monitor.sv
module tb_cpu_trace_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, clear, halt_i, reg_we_i, mem_re_i, mem_we_i, trace_ready;
  logic [3:0]  reg_rd_i;
  logic [15:0] reg_data_i, mem_addr_i, mem_data_i;
  logic [4:0]  event_i;

  // default instance
  logic         tv, ovf;
  logic [1:0]   ttype, st;
  logic [15:0]  taddr, tdata;
  logic [31:0]  cyc, inst, drop;
  logic [159:0] evc;
  // WDOG_LIMIT = 20 instance
  logic         tv_w, ovf_w;
  logic [1:0]   ttype_w, st_w;
  logic [15:0]  taddr_w, tdata_w;
  logic [31:0]  cyc_w, inst_w, drop_w;
  logic [159:0] evc_w;
  // CNT_W = 4 instance
  logic         tv_c, ovf_c;
  logic [1:0]   ttype_c, st_c;
  logic [15:0]  taddr_c, tdata_c;
  logic [3:0]   cyc_c, inst_c, drop_c;
  logic [19:0]  evc_c;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] mon_q[$];

  cpu_trace_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .halt_i(halt_i),
    .reg_we_i(reg_we_i), .reg_rd_i(reg_rd_i), .reg_data_i(reg_data_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .event_i(event_i), .trace_valid(tv),
    .trace_ready(trace_ready), .trace_type(ttype), .trace_addr(taddr),
    .trace_data(tdata), .cycle_cnt(cyc), .inst_cnt(inst), .event_cnt(evc),
    .drop_cnt(drop), .state_o(st), .overflow(ovf));

  cpu_trace_monitor #(.WDOG_LIMIT(20)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .halt_i(halt_i),
    .reg_we_i(reg_we_i), .reg_rd_i(reg_rd_i), .reg_data_i(reg_data_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .event_i(event_i), .trace_valid(tv_w),
    .trace_ready(trace_ready), .trace_type(ttype_w), .trace_addr(taddr_w),
    .trace_data(tdata_w), .cycle_cnt(cyc_w), .inst_cnt(inst_w), .event_cnt(evc_w),
    .drop_cnt(drop_w), .state_o(st_w), .overflow(ovf_w));

  cpu_trace_monitor #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .halt_i(halt_i),
    .reg_we_i(reg_we_i), .reg_rd_i(reg_rd_i), .reg_data_i(reg_data_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .event_i(event_i), .trace_valid(tv_c),
    .trace_ready(trace_ready), .trace_type(ttype_c), .trace_addr(taddr_c),
    .trace_data(tdata_c), .cycle_cnt(cyc_c), .inst_cnt(inst_c), .event_cnt(evc_c),
    .drop_cnt(drop_c), .state_o(st_c), .overflow(ovf_c));

  // Records every entry the consumer accepts on the following rising edge.
  always @(negedge clk) begin
    if (tv && trace_ready) mon_q.push_back({ttype, taddr, tdata});
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; halt_i = 0; reg_we_i = 0; mem_re_i = 0; mem_we_i = 0;
    reg_rd_i = '0; reg_data_i = '0; mem_addr_i = '0; mem_data_i = '0; event_i = '0;
  endtask

  task automatic clear_start();
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; trace_ready = 0; idle_inputs();
    step(2);
    n_checks++; if (tv !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tv); end
    n_checks++; if (st !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st); end
    n_checks++; if ({cyc, inst, drop, ovf} !== '0) begin n_fail++; $display("FAIL reset_counters: cyc %0d inst %0d drop %0d ovf %b want all 0", cyc, inst, drop, ovf); end
    n_checks++; if (evc !== '0) begin n_fail++; $display("FAIL reset_events: got %h want 0", evc); end
    n_checks++; if ({ttype, taddr, tdata} !== 34'd0) begin n_fail++; $display("FAIL reset_head: got %h want 0", {ttype, taddr, tdata}); end
    rst_n = 1;
    reg_we_i = 1; mem_we_i = 1; halt_i = 1; event_i = '1;
    step(3);
    n_checks++; if ({tv, st, cyc, inst} !== '0) begin n_fail++; $display("FAIL idle_ignores_inputs: tv %b st %0d cyc %0d inst %0d want all 0", tv, st, cyc, inst); end
    idle_inputs();
  endtask

  task automatic test_reg_stream();
    idle_inputs(); trace_ready = 1;
    clear_start();
    mon_q.delete();
    reg_we_i = 1; reg_rd_i = 4'd3; reg_data_i = 16'h00A5;
    step();
    n_checks++; if (tv !== 1'b1) begin n_fail++; $display("FAIL first_entry_latency: valid %b want 1", tv); end
    step(9);
    n_checks++; if (cyc !== 32'd10) begin n_fail++; $display("FAIL reg_cycle_cnt: got %0d want 10", cyc); end
    n_checks++; if (inst !== 32'd10) begin n_fail++; $display("FAIL reg_inst_cnt: got %0d want 10", inst); end
    n_checks++; if (st !== 2'd1) begin n_fail++; $display("FAIL reg_state: got %0d want 1", st); end
  endtask

  task automatic test_halt_cycle();
    logic [33:0] exp_e, got_e;
    mem_we_i = 1; mem_addr_i = 16'h0040; mem_data_i = 16'h1234; halt_i = 1;
    step();
    halt_i = 0; mem_we_i = 0;
    n_checks++; if (st !== 2'd2) begin n_fail++; $display("FAIL halt_state: got %0d want 2", st); end
    n_checks++; if (inst !== 32'd11) begin n_fail++; $display("FAIL halt_inst_cnt: got %0d want 11", inst); end
    n_checks++; if (cyc !== 32'd11) begin n_fail++; $display("FAIL halt_cycle_cnt: got %0d want 11", cyc); end
    event_i = '1;
    step(3);
    n_checks++; if ({cyc, inst} !== {32'd11, 32'd11}) begin n_fail++; $display("FAIL halted_frozen: cyc %0d inst %0d want 11 11", cyc, inst); end
    n_checks++; if (evc !== '0) begin n_fail++; $display("FAIL halted_events_frozen: got %h want 0", evc); end
    reg_we_i = 0; event_i = '0;
    step(4);
    n_checks++; if (mon_q.size() != 13) begin n_fail++; $display("FAIL halt_stream_len: got %0d want 13", mon_q.size()); end
    for (int i = 0; i < 13; i++) begin
      if (i < 11)       exp_e = {2'd0, 16'd3, 16'h00A5};
      else if (i == 11) exp_e = {2'd2, 16'h0040, 16'h1234};
      else              exp_e = {2'd3, 16'd0, 16'd11};
      got_e = '1;
      if (i < mon_q.size()) got_e = mon_q[i];
      n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL halt_stream_entry %0d: got %h want %h", i, got_e, exp_e); end
    end
    n_checks++; if (tv !== 1'b0) begin n_fail++; $display("FAIL halt_drained: valid %b want 0", tv); end
  endtask

  task automatic test_overflow();
    logic [33:0] exp_e, got_e;
    idle_inputs(); trace_ready = 0;
    clear_start();
    mon_q.delete();
    reg_we_i = 1; reg_rd_i = 4'd7; reg_data_i = 16'h0101;
    mem_re_i = 1; mem_addr_i = 16'h0080; mem_data_i = 16'h5555;
    step(8);
    n_checks++; if (drop !== 32'd10) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 10", drop); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_checks++; if (inst !== 32'd8) begin n_fail++; $display("FAIL ovf_inst_cnt: got %0d want 8", inst); end
    reg_we_i = 0; mem_re_i = 0; halt_i = 1;
    step();
    halt_i = 0;
    n_checks++; if ({st, drop} !== {2'd2, 32'd10}) begin n_fail++; $display("FAIL ovf_halt_accept: state %0d drop %0d want 2 10", st, drop); end
    trace_ready = 1;
    step(10);
    n_checks++; if (mon_q.size() != 7) begin n_fail++; $display("FAIL ovf_stream_len: got %0d want 7", mon_q.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i == 6)          exp_e = {2'd3, 16'd0, 16'd9};
      else if (i % 2 == 0) exp_e = {2'd0, 16'd7, 16'h0101};
      else                 exp_e = {2'd1, 16'h0080, 16'h5555};
      got_e = '1;
      if (i < mon_q.size()) got_e = mon_q[i];
      n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL ovf_stream_entry %0d: got %h want %h", i, got_e, exp_e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_e, got_e, held;
    logic stalled;
    int k;
    idle_inputs(); trace_ready = 0;
    clear_start();
    mon_q.delete();
    k = 0;
    for (int i = 0; i < 30; i++) begin
      reg_we_i = (i % 3 != 0);
      if (reg_we_i) begin
        reg_rd_i = k[3:0]; reg_data_i = 16'h0100 + k[15:0]; k++;
      end
      trace_ready = (i % 2 == 1);
      stalled = tv && !trace_ready;
      held = {ttype, taddr, tdata};
      step();
      if (stalled) begin
        n_checks++; if ({ttype, taddr, tdata} !== held) begin n_fail++; $display("FAIL b2b_head_stable cycle %0d: got %h want %h", i, {ttype, taddr, tdata}, held); end
      end
    end
    reg_we_i = 0; trace_ready = 1;
    step(12);
    n_checks++; if (mon_q.size() != 20) begin n_fail++; $display("FAIL b2b_stream_len: got %0d want 20", mon_q.size()); end
    n_checks++; if (drop !== 32'd0) begin n_fail++; $display("FAIL b2b_no_drop: got %0d want 0", drop); end
    for (int i = 0; i < 20; i++) begin
      exp_e = {2'd0, 16'(i % 16), 16'(16'h0100 + i)};
      got_e = '1;
      if (i < mon_q.size()) got_e = mon_q[i];
      n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL b2b_entry %0d: got %h want %h", i, got_e, exp_e); end
    end
  endtask

  task automatic test_watchdog();
    idle_inputs(); trace_ready = 1;
    clear_start();
    reg_we_i = 1; reg_rd_i = 4'd1; reg_data_i = 16'd1; event_i = 5'b00001;
    step(19);
    n_checks++; if ({st_w, cyc_w} !== {2'd1, 32'd19}) begin n_fail++; $display("FAIL wdog_before: state %0d cyc %0d want 1 19", st_w, cyc_w); end
    step();
    n_checks++; if ({st_w, cyc_w} !== {2'd3, 32'd20}) begin n_fail++; $display("FAIL wdog_timeout: state %0d cyc %0d want 3 20", st_w, cyc_w); end
    step(3);
    n_checks++; if ({st_w, cyc_w, inst_w, evc_w[31:0]} !== {2'd3, 32'd20, 32'd20, 32'd20}) begin
      n_fail++; $display("FAIL wdog_frozen: state %0d cyc %0d inst %0d ev0 %0d want 3 20 20 20", st_w, cyc_w, inst_w, evc_w[31:0]);
    end
    idle_inputs();
    clear_start();
    step(19);
    halt_i = 1;
    step();
    halt_i = 0;
    n_checks++; if ({st_w, cyc_w, inst_w} !== {2'd2, 32'd20, 32'd1}) begin n_fail++; $display("FAIL wdog_halt_wins: state %0d cyc %0d inst %0d want 2 20 1", st_w, cyc_w, inst_w); end
  endtask

  task automatic test_saturate_clear();
    idle_inputs(); trace_ready = 1;
    clear_start();
    event_i = 5'b00100;
    step(20);
    n_checks++; if (evc_c[11:8] !== 4'd15) begin n_fail++; $display("FAIL sat_event2: got %0d want 15", evc_c[11:8]); end
    n_checks++; if (cyc_c !== 4'd15) begin n_fail++; $display("FAIL sat_cycle: got %0d want 15", cyc_c); end
    n_checks++; if ({evc_c[19:12], evc_c[7:0]} !== 16'd0) begin n_fail++; $display("FAIL sat_other_events: got %h want 0", evc_c); end
    n_checks++; if (st_c !== 2'd1) begin n_fail++; $display("FAIL sat_state: got %0d want 1", st_c); end
    clear = 1; start = 1;
    step();
    clear = 0; start = 0;
    n_checks++; if ({st_c, cyc_c, inst_c, drop_c, evc_c, ovf_c} !== '0) begin n_fail++; $display("FAIL clear_mid_run: state %0d cyc %0d evc %h want 0", st_c, cyc_c, evc_c); end
    n_checks++; if ({st, cyc} !== '0) begin n_fail++; $display("FAIL clear_beats_start: state %0d cyc %0d want 0 0", st, cyc); end
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs(); trace_ready = 0;
    clear_start();
    reg_we_i = 1; reg_rd_i = 4'd2; reg_data_i = 16'hBEEF;
    step(3);
    reg_we_i = 0;
    n_checks++; if (tv !== 1'b1) begin n_fail++; $display("FAIL drain_pending: valid %b want 1", tv); end
    #2 rst_n = 0;
    #1;
    n_checks++; if ({tv, st, cyc} !== '0) begin n_fail++; $display("FAIL async_reset: valid %b state %0d cyc %0d want 0", tv, st, cyc); end
    step();
    rst_n = 1;
    trace_ready = 1;
    step(2);
    n_checks++; if (tv !== 1'b0) begin n_fail++; $display("FAIL reset_flushes_fifo: valid %b want 0", tv); end
  endtask

  initial begin
    test_reset();
    test_reg_stream();
    test_halt_cycle();
    test_overflow();
    test_back_to_back();
    test_watchdog();
    test_saturate_clear();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
